// File: rtl/instr_exec_reader_if.sv
// Result/instruction bus between instr_exec_reader (master) and the register stack / checker (slave).
// INSTR_EXEC_DIVZERO_FLAG_EN adds the div_zero qualifier alongside the result.
interface instr_exec_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RES_W  = 64
);
  localparam int unsigned OPC_W = 4;
  localparam int unsigned OP_W  = 32;
  localparam int unsigned IW_W  = OPC_W + 2 * OP_W;

  logic [ADDR_W-1:0]       read_pointer;
  logic [IW_W-1:0]         instruction_word;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [RES_W-1:0] result;
  logic [OPC_W-1:0]        res_opc;
  logic [ADDR_W-1:0]       res_ptr;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  logic                    div_zero;

  modport master (
    output read_pointer, res_valid, result, res_opc, res_ptr, div_zero,
    input  instruction_word, res_ready
  );
  modport slave (
    input  read_pointer, res_valid, result, res_opc, res_ptr, div_zero,
    output instruction_word, res_ready
  );
`else
  modport master (
    output read_pointer, res_valid, result, res_opc, res_ptr,
    input  instruction_word, res_ready
  );
  modport slave (
    input  read_pointer, res_valid, result, res_opc, res_ptr,
    output instruction_word, res_ready
  );
`endif
endinterface

// File: rtl/instr_exec_reader.sv
// Walks read_pointer over a programmed range, executes each instruction and hands out one result per entry.
// Optional feature macro: INSTR_EXEC_DIVZERO_FLAG_EN (adds bus.div_zero).
module instr_exec_reader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RES_W  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   first_ptr_i,
  input  logic [ADDR_W:0]     count_i,
  output logic                busy_o,
  output logic                done_o,
  instr_exec_reader_if.master bus
);
  localparam int unsigned OPC_W = 4;
  localparam int unsigned OP_W  = 32;
  localparam int unsigned IW_W  = OPC_W + 2 * OP_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [OPC_W-1:0] OPC_ZERO  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic                    res_valid_q, res_valid_d;
  logic signed [RES_W-1:0] result_q, result_d;
  logic [OPC_W-1:0]        res_opc_q, res_opc_d;
  logic [ADDR_W-1:0]       res_ptr_q, res_ptr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  logic                    div_zero_q, div_zero_d;
  logic                    div_zero_c;
`endif

  logic [OPC_W-1:0]        iw_opc;
  logic signed [OP_W-1:0]  iw_a;
  logic signed [OP_W-1:0]  iw_b;
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] exec_res_c;
  logic                    b_zero_c;
  logic                    hs_c;

  // Instruction word layout is {opc, op_a, op_b}, opc in the top bits.
  assign iw_opc   = bus.instruction_word[IW_W-1 -: OPC_W];
  assign iw_a     = bus.instruction_word[2*OP_W-1 -: OP_W];
  assign iw_b     = bus.instruction_word[OP_W-1:0];
  assign a_ext    = {{(RES_W-OP_W){iw_a[OP_W-1]}}, iw_a};
  assign b_ext    = {{(RES_W-OP_W){iw_b[OP_W-1]}}, iw_b};
  assign b_zero_c = (iw_b == '0);

  // Divide/modulo by zero and unknown opcodes deliberately collapse to zero.
  always_comb begin
    exec_res_c = '0;
    case (iw_opc)
      OPC_ZERO:  exec_res_c = '0;
      OPC_PASSA: exec_res_c = a_ext;
      OPC_PASSB: exec_res_c = b_ext;
      OPC_ADD:   exec_res_c = a_ext + b_ext;
      OPC_SUB:   exec_res_c = a_ext - b_ext;
      OPC_MULT:  exec_res_c = a_ext * b_ext;
      OPC_DIV:   if (!b_zero_c) exec_res_c = a_ext / b_ext;
      OPC_MOD:   if (!b_zero_c) exec_res_c = a_ext % b_ext;
      default:   exec_res_c = '0;
    endcase
  end

`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  assign div_zero_c = ((iw_opc == OPC_DIV) || (iw_opc == OPC_MOD)) && b_zero_c;
`endif

  assign hs_c = (state_q == S_OUTPUT) && res_valid_q && bus.res_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // remaining_q == 1 on a handshake means the entry just accepted was the last one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (count_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:  state_d = S_EXEC;
      S_EXEC:   state_d = S_OUTPUT;
      S_OUTPUT: begin
        if (hs_c) begin
          state_d = (remaining_q == CNT_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    res_opc_d   = res_opc_q;
    res_ptr_d   = res_ptr_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
    div_zero_d  = div_zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i && (count_i != '0)) begin
          rd_ptr_d    = first_ptr_i;
          remaining_d = count_i;
        end
      end
      S_EXEC: begin
        result_d    = exec_res_c;
        res_opc_d   = iw_opc;
        res_ptr_d   = rd_ptr_q;
        res_valid_d = 1'b1;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
        div_zero_d  = div_zero_c;
`endif
      end
      S_OUTPUT: begin
        if (hs_c) begin
          res_valid_d = 1'b0;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q != CNT_W'(1)) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      res_opc_q   <= OPC_ZERO;
      res_ptr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      res_opc_q   <= res_opc_d;
      res_ptr_q   <= res_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
      div_zero_q  <= div_zero_d;
`endif
    end
  end

  assign bus.read_pointer = rd_ptr_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.result       = result_q;
  assign bus.res_opc      = res_opc_q;
  assign bus.res_ptr      = res_ptr_q;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  assign bus.div_zero     = div_zero_q;
`endif
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_instr_exec_reader.sv
// Bench for instr_exec_reader: a register-stack model feeds instructions, a scoreboard checks results.
module tb_instr_exec_reader;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned DEPTH  = 32;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  opc;
    logic [4:0]  ptr;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  first_ptr_i = '0;
  logic [5:0]  count_i = '0;
  logic        busy_o;
  logic        done_o;

  logic [67:0] iw_mem [DEPTH];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;

  instr_exec_reader_if #(.ADDR_W(ADDR_W), .RES_W(RES_W)) bus();

  assign bus.instruction_word = iw_mem[bus.read_pointer];

  instr_exec_reader #(.ADDR_W(ADDR_W), .RES_W(RES_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .first_ptr_i (first_ptr_i),
    .count_i     (count_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] mk(input logic [3:0] opc, input int a, input int b);
    return {opc, a, b};
  endfunction

  // Reference: operands are plain 32-bit ints widened to longint, SV division semantics.
  function automatic exp_t model(input logic [67:0] iw, input logic [4:0] p);
    exp_t   e;
    int     ai, bi;
    longint a, b, r;
    ai = iw[63:32];
    bi = iw[31:0];
    a  = ai;
    b  = bi;
    case (iw[67:64])
      4'd1:    r = a;
      4'd2:    r = b;
      4'd3:    r = a + b;
      4'd4:    r = a - b;
      4'd5:    r = a * b;
      4'd6:    r = (b == 0) ? 0 : a / b;
      4'd7:    r = (b == 0) ? 0 : a % b;
      default: r = 0;
    endcase
    e.res = r;
    e.opc = iw[67:64];
    e.ptr = p;
    e.dz  = ((iw[67:64] == 4'd6) || (iw[67:64] == 4'd7)) && (b == 0);
    return e;
  endfunction

  task automatic push_model(input logic [4:0] fp, input int cnt);
    logic [4:0] p;
    for (int i = 0; i < cnt; i++) begin
      p = fp + 5'(i);
      sb.push_back(model(iw_mem[p], p));
    end
  endtask

  task automatic push_const(input longint r, input logic [3:0] opc, input logic [4:0] p, input logic dz);
    exp_t e;
    e.res = r;
    e.opc = opc;
    e.ptr = p;
    e.dz  = dz;
    sb.push_back(e);
  endtask

  task automatic fill_random();
    logic [3:0] o;
    int a, b;
    for (int i = 0; i < int'(DEPTH); i++) begin
      o = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      a = int'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 0;
        1:       b = int'($urandom_range(0, 20)) - 10;
        default: b = int'($urandom);
      endcase
      iw_mem[i] = mk(o, a, b);
    end
  endtask

  task automatic issue_start(input logic [4:0] fp, input logic [5:0] cnt);
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    first_ptr_i = fp;
    count_i     = cnt;
    @(posedge clk);
    #1;
    start_i     = 1'b0;
    first_ptr_i = 5'($urandom);
    count_i     = 6'($urandom);
    chk("busy_after_start", 64'(busy_o), 64'(1));
  endtask

  task automatic wait_done(input int d0, input int limit, output int n);
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", 64'(done_cnt != d0), 64'(1));
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("done_once", 64'(done_cnt - d0), 64'(1));
    chk("busy_idle", 64'(busy_o), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!bus.res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 64'(bus.res_valid), 64'(1));
  endtask

  task automatic run(input logic [4:0] fp, input logic [5:0] cnt, input bit model_exp);
    int d0, n;
    if (model_exp) push_model(fp, int'(cnt));
    d0 = done_cnt;
    issue_start(fp, cnt);
    wait_done(d0, 20 * int'(cnt) + 20, n);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.res_ready = 1'b1;
    else if (rdy_mode == 1) bus.res_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every handshake, checks hold-stability under backpressure.
  bit          stall_q = 1'b0;
  bit          done_prev = 1'b0;
  logic [63:0] hold_res;
  logic [4:0]  hold_ptr;
  logic [4:0]  hold_rp;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 64'(bus.res_valid), 64'(1));
        chk("hold_result", bus.result, hold_res);
        chk("hold_ptr", 64'(bus.res_ptr), 64'(hold_ptr));
        chk("hold_rdptr", 64'(bus.read_pointer), 64'(hold_rp));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h ptr=%0d required=none", bus.result, bus.res_ptr);
        end else begin
          mon_e = sb.pop_front();
          chk("result", bus.result, mon_e.res);
          chk("res_opc", 64'(bus.res_opc), 64'(mon_e.opc));
          chk("res_ptr", 64'(bus.res_ptr), 64'(mon_e.ptr));
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
          chk("div_zero", 64'(bus.div_zero), 64'(mon_e.dz));
`endif
        end
      end
      stall_q  = bus.res_valid && !bus.res_ready;
      hold_res = bus.result;
      hold_ptr = bus.res_ptr;
      hold_rp  = bus.read_pointer;
      if (done_o) begin
        done_cnt++;
        chk("done_sb_empty", 64'(sb.size()), 64'(0));
        if (done_prev) chk("done_one_cycle", 64'(1), 64'(0));
      end
      done_prev = done_o;
    end
  end

  initial begin
    int d0, n;
    logic [63:0] r0;
    logic [4:0]  p0, rp0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) iw_mem[i] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_result", bus.result, 64'(0));
    chk("rst_opc", 64'(bus.res_opc), 64'(0));
    chk("rst_ptr", 64'(bus.res_ptr), 64'(0));
    chk("rst_rdptr", 64'(bus.read_pointer), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
    chk("rst_div_zero", 64'(bus.div_zero), 64'(0));
`endif
    #2;
    reset_n = 1'b1;

    // Basic ADD/SUB/MULT
    iw_mem[0] = mk(4'd3, 5, 3);
    iw_mem[1] = mk(4'd4, -15, 7);
    iw_mem[2] = mk(4'd5, 12, -4);
    push_const(8, 4'd3, 5'd0, 1'b0);
    push_const(-22, 4'd4, 5'd1, 1'b0);
    push_const(-48, 4'd5, 5'd2, 1'b0);
    run(5'd0, 6'd3, 1'b0);

    // Backpressure on the first result
    @(negedge clk);
    rdy_mode = 2;
    bus.res_ready = 1'b0;
    push_model(5'd0, 2);
    d0 = done_cnt;
    issue_start(5'd0, 6'd2);
    wait_valid(20);
    r0  = bus.result;
    p0  = bus.res_ptr;
    rp0 = bus.read_pointer;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.res_valid), 64'(1));
      chk("bp_result", bus.result, r0);
      chk("bp_ptr", 64'(bus.res_ptr), 64'(p0));
      chk("bp_rdptr", 64'(bus.read_pointer), 64'(rp0));
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    bus.res_ready = 1'b1;
    wait_done(d0, 60, n);

    // Pointer wrap 30,31,0,1
    fill_random();
    run(5'd30, 6'd4, 1'b1);

    // Division corner cases and an out-of-enum opcode
    iw_mem[8]  = mk(4'd6, 9, 0);
    iw_mem[9]  = mk(4'd6, -7, 2);
    iw_mem[10] = mk(4'd7, -7, 2);
    iw_mem[11] = mk(4'd7, 5, 0);
    iw_mem[12] = mk(4'd12, 100, 3);
    iw_mem[13] = mk(4'd7, 7, -2);
    push_const(0, 4'd6, 5'd8, 1'b1);
    push_const(-3, 4'd6, 5'd9, 1'b0);
    push_const(-1, 4'd7, 5'd10, 1'b0);
    push_const(0, 4'd7, 5'd11, 1'b1);
    push_const(0, 4'd12, 5'd12, 1'b0);
    push_const(1, 4'd7, 5'd13, 1'b0);
    run(5'd8, 6'd6, 1'b0);

    // count == 0: immediate done, no result
    d0 = done_cnt;
    issue_start(5'd7, 6'd0);
    wait_done(d0, 10, n);
    chk("cnt0_done_latency", 64'(n), 64'(1));
    chk("cnt0_no_valid", 64'(bus.res_valid), 64'(0));

    // start while busy must be ignored
    fill_random();
    rdy_mode = 1;
    push_model(5'd20, 5);
    d0 = done_cnt;
    issue_start(5'd20, 6'd5);
    repeat (4) @(posedge clk);
    #1;
    start_i = 1'b1;
    first_ptr_i = 5'd2;
    count_i = 6'd9;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(d0, 200, n);

    // Randomized runs with random backpressure, including a full-depth sweep
    for (int k = 0; k < 8; k++) begin
      logic [5:0] c;
      fill_random();
      c = (k == 7) ? 6'd32 : 6'($urandom_range(1, 12));
      run(5'($urandom), c, 1'b1);
    end
    rdy_mode = 0;

    // Reset during OUTPUT: result dropped, no done
    @(negedge clk);
    rdy_mode = 2;
    bus.res_ready = 1'b0;
    fill_random();
    push_model(5'd3, 3);
    issue_start(5'd3, 6'd3);
    wait_valid(20);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.res_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_rdptr", 64'(bus.read_pointer), 64'(0));
    chk("mid_rst_result", bus.result, 64'(0));
    sb.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    chk("mid_rst_idle_valid", 64'(bus.res_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
